// File: rtl/score_keeper.sv
// Top-level game FSM (IDLE/PLAY/OVER) with a saturating two-digit BCD score,
// a BCD high score and the run enable that freezes motion outside PLAY.
module score_keeper #(
    parameter int unsigned OVER_HOLD = 16,
    parameter int unsigned MAX_TENS  = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       increment,
    input  logic       game_over,
    output logic       run,
    output logic [1:0] state,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] high_ones,
    output logic [3:0] high_tens,
    output logic       new_record
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(OVER_HOLD - 1);
    localparam logic [3:0] TENS_MAX  = 4'(MAX_TENS);

    state_t     state_q;
    logic       start_q;
    logic       inc_q;
    logic       run_q;
    logic       new_record_q;
    logic [7:0] hold_q;
    logic [7:0] score_q;
    logic [7:0] high_q;
    logic       start_e;
    logic       inc_e;
    logic [7:0] score_d;

    // BCD {tens,ones} increment that sticks at MAX_TENS/9 instead of wrapping
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if ((v[7:4] == TENS_MAX) && (v[3:0] == 4'd9)) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign start_e = start & ~start_q;
    assign inc_e   = increment & ~inc_q;
    assign score_d = bcd_inc(score_q);

    // Game state machine, score/high-score keeping and edge registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            inc_q        <= 1'b0;
            run_q        <= 1'b0;
            new_record_q <= 1'b0;
            hold_q       <= 8'd0;
            score_q      <= 8'h00;
            high_q       <= 8'h00;
        end else begin
            start_q <= start;
            inc_q   <= increment;
            case (state_q)
                ST_IDLE: begin
                    if (start_e) begin
                        state_q <= ST_PLAY;
                        score_q <= 8'h00;
                        run_q   <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Valid BCD digits compare correctly as a plain binary byte
                    if (game_over) begin
                        state_q <= ST_OVER;
                        run_q   <= 1'b0;
                        hold_q  <= 8'd0;
                        if (score_q > high_q) begin
                            high_q       <= score_q;
                            new_record_q <= 1'b1;
                        end else begin
                            new_record_q <= 1'b0;
                        end
                    end else if (inc_e) begin
                        score_q <= score_d;
                    end
                end
                ST_OVER: begin
                    if (start_e && (hold_q == HOLD_LAST)) begin
                        state_q      <= ST_PLAY;
                        score_q      <= 8'h00;
                        new_record_q <= 1'b0;
                        run_q        <= 1'b1;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    run_q        <= 1'b0;
                    new_record_q <= 1'b0;
                end
            endcase
        end
    end

    assign run        = run_q;
    assign state      = state_q;
    assign score_ones = score_q[3:0];
    assign score_tens = score_q[7:4];
    assign high_ones  = high_q[3:0];
    assign high_tens  = high_q[7:4];
    assign new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random play,
// all compared against an integer-arithmetic game model.
module tb_score_keeper;
    localparam int OVER_HOLD = 16;
    localparam int MAX_SCORE = 99;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       increment = 1'b0;
    logic       game_over = 1'b0;
    logic       run;
    logic [1:0] state;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [3:0] high_ones;
    logic [3:0] high_tens;
    logic       new_record;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 play, 2 over; scores as plain integers
    int m_state;
    int m_score;
    int m_high;
    int m_over_cycles;
    bit m_rec;
    bit m_start_prev;
    bit m_inc_prev;

    always #5 clock = ~clock;

    score_keeper #(.OVER_HOLD(OVER_HOLD), .MAX_TENS(9)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .increment  (increment),
        .game_over  (game_over),
        .run        (run),
        .state      (state),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .high_ones  (high_ones),
        .high_tens  (high_tens),
        .new_record (new_record)
    );

    function automatic logic [19:0] dut_vec();
        return {state, run, score_tens, score_ones, high_tens, high_ones, new_record};
    endfunction

    function automatic logic [19:0] model_vec();
        logic [1:0] s;
        logic       r;
        s = 2'(m_state);
        r = (m_state == 1);
        return {s, r, 4'(m_score / 10), 4'(m_score % 10),
                4'(m_high / 10), 4'(m_high % 10), m_rec};
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_over_cycles = 0;
        m_rec = 1'b0; m_start_prev = 1'b0; m_inc_prev = 1'b0;
    endtask

    task automatic model_clock();
        bit s_e;
        bit i_e;
        s_e = start && !m_start_prev;
        i_e = increment && !m_inc_prev;
        m_start_prev = start;
        m_inc_prev   = increment;
        if (m_state == 0) begin
            if (s_e) begin m_state = 1; m_score = 0; end
        end else if (m_state == 1) begin
            if (game_over) begin
                m_state = 2;
                m_over_cycles = 0;
                m_rec = (m_score > m_high);
                if (m_score > m_high) m_high = m_score;
            end else if (i_e && m_score < MAX_SCORE) begin
                m_score = m_score + 1;
            end
        end else begin
            if (s_e && m_over_cycles >= OVER_HOLD - 1) begin
                m_state = 1; m_score = 0; m_rec = 1'b0;
            end else begin
                m_over_cycles = m_over_cycles + 1;
            end
        end
    endtask

    // Drive inputs at the falling edge, clock once, return at the next falling edge
    task automatic step(input bit s, input bit i, input bit g);
        start = s; increment = i; game_over = g;
        @(posedge clock);
        model_clock();
        @(negedge clock);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clock);
        n_cmp++;
        if (dut_vec() !== 20'h00000) begin
            n_err++; $display("FAIL reset_values: got %h want %h", dut_vec(), 20'h00000);
        end
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL idle_ignores: got %h want %h", dut_vec(), model_vec());
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start();
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({state, run, score_tens, score_ones} !== 11'b01_1_0000_0000) begin
            n_err++; $display("FAIL start_play: got %b want %b",
                {state, run, score_tens, score_ones}, 11'b01_1_0000_0000);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL start_settle: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_increment_levels();
        for (int k = 0; k < 15; k++) begin
            step(1'b0, (k < 10) || (k >= 12), 1'b0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL inc_level[%0d]: got %h want %h", k, dut_vec(), model_vec());
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h02) begin
            n_err++; $display("FAIL inc_edges: got %h want %h", {score_tens, score_ones}, 8'h02);
        end
    endtask

    task automatic test_game_over_priority();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({state, high_tens, high_ones, new_record} !== 11'b10_0000_0011_1) begin
            n_err++; $display("FAIL first_over: got %b want %b",
                {state, high_tens, high_ones, new_record}, 11'b10_0000_0011_1);
        end
        repeat (18) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL restart: got %h want %h", dut_vec(), model_vec());
        end
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({score_tens, score_ones, high_tens, high_ones} !== 16'h0503) begin
            n_err++; $display("FAIL pre_collide: got %h want %h",
                {score_tens, score_ones, high_tens, high_ones}, 16'h0503);
        end
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (dut_vec() !== {2'b10, 1'b0, 16'h0505, 1'b1}) begin
            n_err++; $display("FAIL over_wins: got %h want %h", dut_vec(), {2'b10, 1'b0, 16'h0505, 1'b1});
        end
    endtask

    task automatic test_over_hold();
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({state, run} !== 3'b100) begin
            n_err++; $display("FAIL early_start: got %b want %b", {state, run}, 3'b100);
        end
        repeat (14) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== {2'b01, 1'b1, 16'h0005, 1'b0}) begin
            n_err++; $display("FAIL late_start: got %h want %h", dut_vec(), {2'b01, 1'b1, 16'h0005, 1'b0});
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_second_game();
        repeat (2) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut_vec() !== {2'b10, 1'b0, 16'h0205, 1'b0}) begin
            n_err++; $display("FAIL no_record: got %h want %h", dut_vec(), {2'b10, 1'b0, 16'h0205, 1'b0});
        end
        repeat (14) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (state !== 2'b10) begin
            n_err++; $display("FAIL hold_boundary_reject: got %b want %b", state, 2'b10);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== model_vec() || state !== 2'b01) begin
            n_err++; $display("FAIL hold_boundary_accept: got %h want %h", dut_vec(), model_vec());
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== 20'h00000) begin
            n_err++; $display("FAIL async_reset: got %h want %h", dut_vec(), 20'h00000);
        end
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL post_reset: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturate();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h12) begin
            n_err++; $display("FAIL twelve: got %h want %h", {score_tens, score_ones}, 8'h12);
        end
        for (int k = 0; k < 87; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h99) begin
            n_err++; $display("FAIL reach_99: got %h want %h", {score_tens, score_ones}, 8'h99);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h99) begin
            n_err++; $display("FAIL saturate: got %h want %h", {score_tens, score_ones}, 8'h99);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL record_99: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_increment_levels();
        test_game_over_priority();
        test_over_hold();
        test_second_game();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
